// File: rtl/fifo_pop_serializer_pkg.sv
// Shared typedefs and helpers for the FIFO pop-side serializer.
// The state enum is kept here so checkers and wrappers can decode busy/state consistently.
package fifo_pop_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // Beat counter width; a single-beat word still gets a 1-bit (constant zero) counter.
   function automatic int unsigned cnt_width(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/fifo_pop_serializer.sv
// Pops one wide word at a time from a fifo_v3 drain port and streams it out as RATIO
// narrower valid/ready beats, marking the final slice of each word with last_o.
module fifo_pop_serializer
   import fifo_pop_serializer_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned RATIO     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clr_i,
   input  logic                      fifo_empty_i,
   output logic                      fifo_pop_o,
   input  logic [IN_WIDTH-1:0]       fifo_data_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [IN_WIDTH/RATIO-1:0] data_o,
   output logic                      last_o,
   output logic                      busy_o
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO;
   localparam int unsigned CntWidth  = cnt_width(RATIO);
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(RATIO - 1);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

   if (RATIO < 1) begin : g_bad_ratio
      $error("fifo_pop_serializer: RATIO must be at least 1");
   end
   if ((RATIO >= 1) && ((IN_WIDTH % RATIO) != 0)) begin : g_bad_width
      $error("fifo_pop_serializer: IN_WIDTH must be a multiple of RATIO");
   end

   ser_state_e                      state_q;
   logic [IN_WIDTH-1:0]             word_q;
   logic [CntWidth-1:0]             cnt_q;
   logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
   logic [CntWidth-1:0]             sel;
   logic                            in_send;
   logic                            is_last;
   logic                            handshake;

   assign in_send   = (state_q == SEND);
   assign is_last   = (cnt_q == LastCnt);
   assign handshake = in_send & ready_i;

   // Pop only when nothing is held, or when the held word's final beat leaves this cycle.
   assign fifo_pop_o = rst_ni & ~clr_i & ~fifo_empty_i & (~in_send | (handshake & is_last));

   assign slices = word_q;
   assign sel    = MSB_FIRST ? (LastCnt - cnt_q) : cnt_q;

   // All stream outputs derive from flops only, so ready_i never reaches them.
   assign valid_o = in_send;
   assign busy_o  = in_send;
   assign last_o  = in_send & is_last;
   assign data_o  = in_send ? slices[sel] : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else if (fifo_pop_o) begin
         state_q <= SEND;
         word_q  <= fifo_data_i;
         cnt_q   <= '0;
      end else if (handshake) begin
         if (is_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CntOne;
         end
      end
   end

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Bench for fifo_pop_serializer: an LSB-first and an MSB-first instance, each fed by a
// queue-based FIFO, checked against directed vectors and a pending-beat model.
module tb_fifo_pop_serializer;

   logic            clk;
   logic            rst_n;
   logic [1:0]      clr;
   logic [1:0]      empty;
   logic [1:0]      pop;
   logic [1:0][31:0] fdata;
   logic [1:0]      valid;
   logic [1:0]      ready;
   logic [1:0][7:0] dout;
   logic [1:0]      last;
   logic [1:0]      busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;
   logic [1:0] pop_prev;

   logic [31:0] fifo_q [2][$];
   logic [8:0]  exp_q  [2][$];

   typedef struct {
      logic        rst;
      logic        clr;
      logic        rdy;
      int          npush;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        e_pop;
      logic        e_valid;
      logic [7:0]  e_data;
      logic        e_last;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   fifo_pop_serializer #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .fifo_empty_i(empty[0]),
      .fifo_pop_o(pop[0]), .fifo_data_i(fdata[0]), .valid_o(valid[0]), .ready_i(ready[0]),
      .data_o(dout[0]), .last_o(last[0]), .busy_o(busy[0])
   );

   fifo_pop_serializer #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .fifo_empty_i(empty[1]),
      .fifo_pop_o(pop[1]), .fifo_data_i(fdata[1]), .valid_o(valid[1]), .ready_i(ready[1]),
      .data_o(dout[1]), .last_o(last[1]), .busy_o(busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] beat_of(input logic [31:0] w, input int k, input bit msb);
      int idx;
      idx = msb ? (3 - k) : k;
      return w[idx*8 +: 8];
   endfunction

   // Reference: a word popped becomes four pending beats; the block may pop only when
   // no beat is pending or the sole pending beat is being accepted this cycle.
   task automatic model_step(input int d);
      bit         ev;
      bit         hs;
      bit         ep;
      logic [8:0] head;
      ev = (exp_q[d].size() > 0);
      chk($sformatf("valid[%0d]", d), {31'd0, valid[d]}, {31'd0, ev});
      chk($sformatf("busy[%0d]", d), {31'd0, busy[d]}, {31'd0, ev});
      if (ev) begin
         head = exp_q[d][0];
         chk($sformatf("data[%0d]", d), {24'd0, dout[d]}, {24'd0, head[7:0]});
         chk($sformatf("last[%0d]", d), {31'd0, last[d]}, {31'd0, head[8]});
      end
      hs = ev && ready[d] && !clr[d] && rst_n;
      ep = rst_n && !clr[d] && !empty[d] && ((exp_q[d].size() == 0) || (hs && exp_q[d].size() == 1));
      chk($sformatf("pop[%0d]", d), {31'd0, pop[d]}, {31'd0, ep});
      if (!rst_n || clr[d]) begin
         exp_q[d].delete();
      end else begin
         if (hs) void'(exp_q[d].pop_front());
         if (ep) begin
            for (int k = 0; k < 4; k++) exp_q[d].push_back({(k == 3), beat_of(fdata[d], k, d == 1)});
         end
      end
   endtask

   task automatic cycle(input logic r, input logic [1:0] c, input logic [1:0] rd);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (pop_prev[d] && fifo_q[d].size() > 0) void'(fifo_q[d].pop_front());
      end
      rst_n = r;
      clr   = c;
      ready = rd;
      for (int d = 0; d < 2; d++) begin
         empty[d] = (fifo_q[d].size() == 0);
         fdata[d] = empty[d] ? 32'd0 : fifo_q[d][0];
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         pop_prev[d] = pop[d];
         if (check_en) model_step(d);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic c, input logic y, input int np,
                               input logic [31:0] a, input logic [31:0] b, input logic ep,
                               input logic ev, input logic [7:0] ed, input logic el);
      vec_t v;
      v.rst = r; v.clr = c; v.rdy = y; v.npush = np; v.w0 = a; v.w1 = b;
      v.e_pop = ep; v.e_valid = ev; v.e_data = ed; v.e_last = el;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] msb_beats [4];
      clk = 1'b0; rst_n = 1'b0; clr = 2'b00; ready = 2'b00;
      empty = 2'b11; fdata = '0; pop_prev = 2'b00;

      // Reset held with a word waiting, then the word streams once reset releases
      vecs.push_back(mk(0, 0, 1, 1, 32'h87654321, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h21, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h43, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h65, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h87, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
      // Single word, LSB slice first
      vecs.push_back(mk(1, 0, 1, 1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hAA, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hCC, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hDD, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
      // Back-to-back words with the second pop on the first word's last beat
      vecs.push_back(mk(1, 0, 1, 2, 32'h03020100, 32'h07060504, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h01, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h02, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 8'h03, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h05, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h06, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h07, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
      // Backpressure on cycles 2-4 holds 0xBB
      vecs.push_back(mk(1, 0, 1, 1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hAA, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hCC, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hDD, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
      // Clear during 0xBB drops the word; the next FIFO word follows
      vecs.push_back(mk(1, 0, 1, 2, 32'hDDCCBBAA, 32'h44332211, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'hAA, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 8'hBB, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h11, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h22, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h33, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 8'h44, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));

      // Power-up cycle: state is unknown until the first reset edge
      cycle(1'b0, 2'b00, 2'b11);
      check_en = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].npush > 0) fifo_q[0].push_back(vecs[i].w0);
         if (vecs[i].npush > 1) fifo_q[0].push_back(vecs[i].w1);
         cycle(vecs[i].rst, {1'b0, vecs[i].clr}, {1'b1, vecs[i].rdy});
         chk($sformatf("vec%0d.pop", i), {31'd0, pop[0]}, {31'd0, vecs[i].e_pop});
         chk($sformatf("vec%0d.valid", i), {31'd0, valid[0]}, {31'd0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d.data", i), {24'd0, dout[0]}, {24'd0, vecs[i].e_data});
            chk($sformatf("vec%0d.last", i), {31'd0, last[0]}, {31'd0, vecs[i].e_last});
         end
      end

      // MSB-first instance: most-significant slice leaves first
      msb_beats[0] = 8'hDD; msb_beats[1] = 8'hCC; msb_beats[2] = 8'hBB; msb_beats[3] = 8'hAA;
      fifo_q[1].push_back(32'hDDCCBBAA);
      cycle(1'b1, 2'b00, 2'b11);
      chk("msb.pop", {31'd0, pop[1]}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 2'b00, 2'b11);
         chk($sformatf("msb.valid%0d", k), {31'd0, valid[1]}, 32'd1);
         chk($sformatf("msb.data%0d", k), {24'd0, dout[1]}, {24'd0, msb_beats[k]});
         chk($sformatf("msb.last%0d", k), {31'd0, last[1]}, (k == 3) ? 32'd1 : 32'd0);
      end
      cycle(1'b1, 2'b00, 2'b11);
      chk("msb.idle", {31'd0, valid[1]}, 32'd0);

      // Random traffic, backpressure, clears and occasional resets on both instances
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [1:0] c;
         logic [1:0] rd;
         for (int d = 0; d < 2; d++) begin
            if (fifo_q[d].size() < 6 && $urandom_range(0, 9) < 4) fifo_q[d].push_back($urandom);
         end
         r  = ($urandom_range(0, 99) != 0);
         c  = {($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0)};
         rd = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         cycle(r, c, rd);
      end
      for (int i = 0; i < 40; i++) cycle(1'b1, 2'b00, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
